// File: rtl/control_sequencer.sv
// control_sequencer: multi-cycle fetch/decode/execute sequencer for the 8-bit datapath.
// Fetches 8-bit instructions over a req/ack port, addresses a 4x8 register file, computes
// the ALU result internally and hands it back as write_data. One instruction per 4 cycles
// with zero fetch wait.
//
// Ports:
//   clk, reset                   clock, synchronous active-high reset
//   run                          execute enable, sampled in IDLE and at end of WRITEBACK
//   imem_addr/req/ack/data       instruction fetch port (addr = pc, req high in FETCH)
//   read_register1/2             register file read addresses (rs, rt)
//   read_data1/2                 register file read data (combinational)
//   write_register/write_data    destination address and result
//   reg_write                    one-cycle write strobe in WRITEBACK for ADD/SUB/LI
//   pc                           program counter
//   busy                         high whenever not IDLE
//   zero_flag, carry_flag        flags of the last ADD/SUB
module control_sequencer #(
  parameter int unsigned PC_W = 5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            run,
  output logic [PC_W-1:0] imem_addr,
  output logic            imem_req,
  input  logic            imem_ack,
  input  logic [7:0]      imem_data,
  output logic [1:0]      read_register1,
  output logic [1:0]      read_register2,
  input  logic [7:0]      read_data1,
  input  logic [7:0]      read_data2,
  output logic [1:0]      write_register,
  output logic [7:0]      write_data,
  output logic            reg_write,
  output logic [PC_W-1:0] pc,
  output logic            busy,
  output logic            zero_flag,
  output logic            carry_flag
);

  localparam logic [2:0] StIdle      = 3'd0;
  localparam logic [2:0] StFetch     = 3'd1;
  localparam logic [2:0] StDecode    = 3'd2;
  localparam logic [2:0] StExecute   = 3'd3;
  localparam logic [2:0] StWriteback = 3'd4;

  localparam logic [1:0] OpAdd = 2'b00;
  localparam logic [1:0] OpSub = 2'b01;
  localparam logic [1:0] OpLi  = 2'b10;
  localparam logic [1:0] OpBnz = 2'b11;

  logic [2:0]      state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [7:0]      instr_q, instr_d;
  logic [7:0]      result_q, result_d;
  logic            zero_q, zero_d;
  logic            carry_q, carry_d;

  logic [1:0]      op;
  logic [8:0]      sum9;
  logic [8:0]      diff9;
  logic [7:0]      li_imm;
  logic [PC_W-1:0] br_off;
  logic [PC_W-1:0] pc_inc;

  assign op     = instr_q[7:6];
  assign sum9   = {1'b0, read_data1} + {1'b0, read_data2};
  // Two's-complement subtract; bit 8 is the no-borrow carry (rs >= rt unsigned).
  assign diff9  = {1'b0, read_data1} + {1'b0, ~read_data2} + 9'd1;
  assign li_imm = {{4{instr_q[5]}}, instr_q[5:2]};
  assign br_off = {{(PC_W-4){instr_q[3]}}, instr_q[3:0]};
  assign pc_inc = pc_q + PC_W'(1);

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    instr_d  = instr_q;
    result_d = result_q;
    zero_d   = zero_q;
    carry_d  = carry_q;
    case (state_q)
      StIdle: begin
        if (run) state_d = StFetch;
      end
      StFetch: begin
        if (imem_ack) begin
          instr_d = imem_data;
          state_d = StDecode;
        end
      end
      StDecode: begin
        state_d = StExecute;
      end
      StExecute: begin
        case (op)
          OpAdd: begin
            result_d = sum9[7:0];
            zero_d   = (sum9[7:0] == 8'h00);
            carry_d  = sum9[8];
          end
          OpSub: begin
            result_d = diff9[7:0];
            zero_d   = (diff9[7:0] == 8'h00);
            carry_d  = diff9[8];
          end
          OpLi: begin
            result_d = li_imm;
          end
          default: ;
        endcase
        state_d = StWriteback;
      end
      StWriteback: begin
        // rs stays on read_register1, so read_data1 is still the branch operand here.
        if (op == OpBnz && read_data1 != 8'h00) pc_d = pc_inc + br_off;
        else                                    pc_d = pc_inc;
        state_d = run ? StFetch : StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      pc_q     <= '0;
      instr_q  <= 8'h00;
      result_q <= 8'h00;
      zero_q   <= 1'b0;
      carry_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      carry_q  <= carry_d;
    end
  end

  // Register addresses come straight from the latched instruction, so they hold from
  // DECODE through WRITEBACK and read zero after reset.
  assign read_register1 = instr_q[5:4];
  assign read_register2 = instr_q[3:2];
  assign write_register = instr_q[1:0];
  assign write_data     = result_q;
  assign imem_addr      = pc_q;
  assign pc             = pc_q;
  assign imem_req       = (state_q == StFetch);
  assign busy           = (state_q != StIdle);
  // Gated by reset so a reset landing in WRITEBACK suppresses the register file write.
  assign reg_write      = (state_q == StWriteback) && (op != OpBnz) && !reset;
  assign zero_flag      = zero_q;
  assign carry_flag     = carry_q;

endmodule
